// File: rtl/ll_pkg.sv
// Shared constants, state encoding and pointer-width helper for the linked-list walker.
package ll_pkg;

  localparam int unsigned NULL_PTR = 0;

  typedef enum logic {
    StIdle,
    StWalk
  } state_e;

  // Pointer width for an N-entry node table; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ll_start_fifo.sv
// Start-request FIFO; the front entry is visible the cycle after it is pushed.
module ll_start_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    do_push = push & (~full | do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_comb begin
    dout  = mem_q[rd_q];
    full  = (cnt_q == CW'(DEPTH));
    empty = (cnt_q == '0);
  end

endmodule

// File: rtl/ll_walker.sv
// Walks singly linked lists held in a next-pointer table, emitting one node per handshake.
module ll_walker
  import ll_pkg::*;
#(
  parameter int unsigned N          = 256,
  parameter int unsigned W_PTR      = ptr_width(N),
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          NO_GAP     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [W_PTR-1:0] cfg_addr,
  input  logic [W_PTR-1:0] cfg_next,
  input  logic [W_PTR-1:0] start,
  input  logic             start_vld,
  output logic             start_rdy,
  output logic [W_PTR-1:0] out_ptr,
  output logic             out_ptr_vld,
  input  logic             out_ptr_rdy,
  output logic             out_last,
  output logic             busy,
  output logic             err_loop
);

  localparam int unsigned      CntW      = W_PTR + 1;
  localparam logic [CntW-1:0]  NodeLimit = CntW'(N);
  localparam logic [W_PTR-1:0] NullPtr   = W_PTR'(NULL_PTR);

  state_e           state_q, state_d;
  logic [W_PTR-1:0] next_q [N];
  logic [W_PTR-1:0] out_ptr_q, out_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [W_PTR-1:0] fifo_head, succ;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             guard, last, head_ok;

  assign fifo_push = start_vld & ~fifo_full;

  ll_start_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (W_PTR)
  ) u_start_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (start),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Lookups read the registered table, so a same-cycle write is seen one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) next_q[i] <= '0;
    end else if (cfg_we) begin
      next_q[cfg_addr] <= cfg_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      out_ptr_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_ptr_q <= out_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    succ    = next_q[out_ptr_q];
    guard   = (cnt_q == NodeLimit);
    last    = (succ == NullPtr) | guard;
    head_ok = ~fifo_empty & (fifo_head != NullPtr);
  end

  always_comb begin
    state_d   = state_q;
    out_ptr_d = out_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Null heads are popped and dropped without producing output.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_ok) begin
            out_ptr_d = fifo_head;
            cnt_d     = CntW'(1);
            state_d   = StWalk;
          end
        end
      end
      StWalk: begin
        if (guard && (succ != NullPtr)) err_d = 1'b1;
        if (out_ptr_rdy) begin
          if (!last) begin
            out_ptr_d = succ;
            cnt_d     = cnt_q + CntW'(1);
          end else if (NO_GAP && head_ok) begin
            fifo_pop  = 1'b1;
            out_ptr_d = fifo_head;
            cnt_d     = CntW'(1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_rdy   = ~fifo_full;
    out_ptr     = out_ptr_q;
    out_ptr_vld = (state_q == StWalk);
    out_last    = out_ptr_vld & last;
    busy        = out_ptr_vld | ~fifo_empty;
    err_loop    = err_q;
  end

endmodule

// File: tb/tb_ll_walker.sv
// Directed bench for ll_walker: one instance per gap mode, shared stimulus.
module tb_ll_walker;

  logic       clk, rst, cfg_we, start_vld, out_ptr_rdy;
  logic [3:0] cfg_addr, cfg_next, start;
  logic       start_rdy0, out_ptr_vld0, out_last0, busy0, err_loop0;
  logic       start_rdy1, out_ptr_vld1, out_last1, busy1, err_loop1;
  logic [3:0] out_ptr0, out_ptr1;

  int checks   = 0;
  int failures = 0;

  logic       mon_en = 1'b0;
  logic [3:0] got_ptr0[$], got_ptr1[$];
  logic       got_last0[$], got_last1[$];
  logic       vld0_tr[$], vld1_tr[$];

  ll_walker #(.N(16), .FIFO_DEPTH(4), .NO_GAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next),
    .start(start), .start_vld(start_vld), .start_rdy(start_rdy0), .out_ptr(out_ptr0),
    .out_ptr_vld(out_ptr_vld0), .out_ptr_rdy(out_ptr_rdy), .out_last(out_last0),
    .busy(busy0), .err_loop(err_loop0)
  );

  ll_walker #(.N(16), .FIFO_DEPTH(4), .NO_GAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next),
    .start(start), .start_vld(start_vld), .start_rdy(start_rdy1), .out_ptr(out_ptr1),
    .out_ptr_vld(out_ptr_vld1), .out_ptr_rdy(out_ptr_rdy), .out_last(out_last1),
    .busy(busy1), .err_loop(err_loop1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Handshakes are recorded mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (mon_en) begin
      vld0_tr.push_back(out_ptr_vld0);
      vld1_tr.push_back(out_ptr_vld1);
      if (out_ptr_vld0 && out_ptr_rdy) begin
        got_ptr0.push_back(out_ptr0);
        got_last0.push_back(out_last0);
      end
      if (out_ptr_vld1 && out_ptr_rdy) begin
        got_ptr1.push_back(out_ptr1);
        got_last1.push_back(out_last1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_ptr0.delete(); got_ptr1.delete();
    got_last0.delete(); got_last1.delete();
    vld0_tr.delete(); vld1_tr.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_next = '0;
    start = '0; start_vld = 1'b0; out_ptr_rdy = 1'b0; mon_en = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] n);
    cfg_we = 1'b1; cfg_addr = a; cfg_next = n;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic push(input logic [3:0] s);
    bit ok = 1'b0;
    start = s; start_vld = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (start_rdy0 && start_rdy1) ok = 1'b1;
      cycle();
    end
    start_vld = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL push_accept start=%0d got=not_accepted exp=accepted", s);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (out_ptr_vld0 !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", out_ptr_vld0); end
    if (out_ptr0 !== 4'd0)     begin failures++; $display("FAIL rst_ptr got=%0d exp=0", out_ptr0); end
    if (out_last0 !== 1'b0)    begin failures++; $display("FAIL rst_last got=%b exp=0", out_last0); end
    if (busy0 !== 1'b0)        begin failures++; $display("FAIL rst_busy got=%b exp=0", busy0); end
    if (err_loop0 !== 1'b0)    begin failures++; $display("FAIL rst_err got=%b exp=0", err_loop0); end
    if (start_rdy0 !== 1'b1)   begin failures++; $display("FAIL rst_rdy got=%b exp=1", start_rdy0); end
  endtask

  task automatic test_latency();
    do_reset();
    out_ptr_rdy = 1'b1;
    push(4'd0);
    checks += 2;
    if (busy0 !== 1'b1 || out_ptr_vld0 !== 1'b0) begin
      failures++; $display("FAIL null_queued busy=%b vld=%b exp busy=1 vld=0", busy0, out_ptr_vld0);
    end
    cycle();
    if (busy0 !== 1'b0 || out_ptr_vld0 !== 1'b0) begin
      failures++; $display("FAIL null_drop busy=%b vld=%b exp busy=0 vld=0", busy0, out_ptr_vld0);
    end
    push(4'd6);
    checks += 2;
    if (out_ptr_vld0 !== 1'b0) begin
      failures++; $display("FAIL lat_front vld=%b exp=0", out_ptr_vld0);
    end
    cycle();
    if (out_ptr_vld0 !== 1'b1 || out_ptr0 !== 4'd6 || out_last0 !== 1'b1) begin
      failures++;
      $display("FAIL lat_first vld=%b ptr=%0d last=%b exp vld=1 ptr=6 last=1",
               out_ptr_vld0, out_ptr0, out_last0);
    end
    cycle();
    checks++;
    if (out_ptr_vld0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL lat_done vld=%b busy=%b exp 0 0", out_ptr_vld0, busy0);
    end
  endtask

  task automatic test_lists();
    int   exp_p[10] = '{7, 15, 8, 6, 2, 4, 1, 5, 3, 10};
    logic exp_l[10] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 1};
    int   first0, last0, first1, last1, gaps0, gaps1;
    do_reset();
    wr(1, 5); wr(5, 3); wr(3, 10); wr(2, 4); wr(7, 15); wr(15, 8);
    out_ptr_rdy = 1'b1;
    clear_mon();
    mon_en = 1'b1;
    push(4'd7); push(4'd6); push(4'd2); push(4'd1);
    for (int i = 0; i < 100 && (got_ptr0.size() < 10 || got_ptr1.size() < 10); i++) cycle();
    repeat (3) cycle();
    mon_en = 1'b0;
    checks += 2;
    if (got_ptr0.size() != 10) begin failures++; $display("FAIL lists_cnt0 got=%0d exp=10", got_ptr0.size()); end
    if (got_ptr1.size() != 10) begin failures++; $display("FAIL lists_cnt1 got=%0d exp=10", got_ptr1.size()); end
    for (int i = 0; i < 10 && i < got_ptr0.size(); i++) begin
      checks++;
      if (got_ptr0[i] !== 4'(exp_p[i]) || got_last0[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL lists_gap0 idx=%0d ptr=%0d last=%b exp ptr=%0d last=%b",
                 i, got_ptr0[i], got_last0[i], exp_p[i], exp_l[i]);
      end
    end
    for (int i = 0; i < 10 && i < got_ptr1.size(); i++) begin
      checks++;
      if (got_ptr1[i] !== 4'(exp_p[i]) || got_last1[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL lists_nogap idx=%0d ptr=%0d last=%b exp ptr=%0d last=%b",
                 i, got_ptr1[i], got_last1[i], exp_p[i], exp_l[i]);
      end
    end
    first0 = -1; last0 = -1; first1 = -1; last1 = -1; gaps0 = 0; gaps1 = 0;
    for (int i = 0; i < vld0_tr.size(); i++) if (vld0_tr[i]) begin if (first0 < 0) first0 = i; last0 = i; end
    for (int i = 0; i < vld1_tr.size(); i++) if (vld1_tr[i]) begin if (first1 < 0) first1 = i; last1 = i; end
    for (int i = first0; i >= 0 && i <= last0; i++) if (!vld0_tr[i]) gaps0++;
    for (int i = first1; i >= 0 && i <= last1; i++) if (!vld1_tr[i]) gaps1++;
    checks += 2;
    if (gaps0 != 3) begin failures++; $display("FAIL gap_idle0 got=%0d exp=3", gaps0); end
    if (gaps1 != 0) begin failures++; $display("FAIL gap_nogap got=%0d exp=0", gaps1); end
  endtask

  task automatic test_backpressure();
    int         exp_p[5] = '{9, 14, 11, 13, 12};
    logic [31:0] pat;
    logic       st, sl;
    logic [3:0] sp;
    pat = 32'hB26C_A396;
    do_reset();
    wr(9, 14); wr(14, 11); wr(11, 13); wr(13, 12);
    out_ptr_rdy = 1'b0;
    clear_mon();
    mon_en = 1'b1;
    push(4'd9);
    for (int i = 0; i < 200 && got_ptr0.size() < 5; i++) begin
      out_ptr_rdy = pat[i % 32];
      st = out_ptr_vld0 && !out_ptr_rdy;
      sp = out_ptr0;
      sl = out_last0;
      cycle();
      if (st) begin
        checks++;
        if (out_ptr_vld0 !== 1'b1 || out_ptr0 !== sp || out_last0 !== sl) begin
          failures++;
          $display("FAIL bp_hold vld=%b ptr=%0d last=%b exp vld=1 ptr=%0d last=%b",
                   out_ptr_vld0, out_ptr0, out_last0, sp, sl);
        end
      end
    end
    mon_en = 1'b0;
    out_ptr_rdy = 1'b1;
    checks++;
    if (got_ptr0.size() != 5) begin failures++; $display("FAIL bp_cnt got=%0d exp=5", got_ptr0.size()); end
    for (int i = 0; i < 5 && i < got_ptr0.size(); i++) begin
      checks++;
      if (got_ptr0[i] !== 4'(exp_p[i]) || got_last0[i] !== (i == 4)) begin
        failures++;
        $display("FAIL bp_order idx=%0d ptr=%0d last=%b exp ptr=%0d last=%b",
                 i, got_ptr0[i], got_last0[i], exp_p[i], (i == 4));
      end
    end
  endtask

  task automatic test_fifo_full();
    int exp_p[7] = '{9, 1, 2, 3, 4, 5, 6};
    int idx;
    do_reset();
    out_ptr_rdy = 1'b0;
    clear_mon();
    mon_en = 1'b1;
    push(4'd9);
    cycle();
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(start_rdy0 && start_rdy1)) break;
      start = 4'(idx + 1);
      start_vld = 1'b1;
      cycle();
      idx++;
    end
    start_vld = 1'b0;
    checks += 3;
    if (idx != 4) begin failures++; $display("FAIL full_accepts got=%0d exp=4", idx); end
    cycle();
    if (start_rdy0 !== 1'b0) begin failures++; $display("FAIL full_rdy got=%b exp=0", start_rdy0); end
    if (out_ptr_vld0 !== 1'b1 || out_ptr0 !== 4'd9 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL full_stall vld=%b ptr=%0d busy=%b exp 1 9 1", out_ptr_vld0, out_ptr0, busy0);
    end
    out_ptr_rdy = 1'b1;
    push(4'd5);
    push(4'd6);
    for (int i = 0; i < 100 && got_ptr0.size() < 7; i++) cycle();
    repeat (3) cycle();
    mon_en = 1'b0;
    checks++;
    if (got_ptr0.size() != 7) begin failures++; $display("FAIL full_cnt got=%0d exp=7", got_ptr0.size()); end
    for (int i = 0; i < 7 && i < got_ptr0.size(); i++) begin
      checks++;
      if (got_ptr0[i] !== 4'(exp_p[i]) || got_last0[i] !== 1'b1) begin
        failures++;
        $display("FAIL full_order idx=%0d ptr=%0d last=%b exp ptr=%0d last=1",
                 i, got_ptr0[i], got_last0[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_loop_guard();
    do_reset();
    wr(3, 3);
    out_ptr_rdy = 1'b1;
    clear_mon();
    mon_en = 1'b1;
    push(4'd3);
    checks++;
    if (err_loop0 !== 1'b0) begin failures++; $display("FAIL loop_err_early got=%b exp=0", err_loop0); end
    repeat (40) cycle();
    mon_en = 1'b0;
    checks += 4;
    if (got_ptr0.size() != 16) begin failures++; $display("FAIL loop_cnt got=%0d exp=16", got_ptr0.size()); end
    if (err_loop0 !== 1'b1 || err_loop1 !== 1'b1) begin
      failures++; $display("FAIL loop_err got=%b/%b exp=1/1", err_loop0, err_loop1);
    end
    if (out_ptr_vld0 !== 1'b0) begin failures++; $display("FAIL loop_end vld=%b exp=0", out_ptr_vld0); end
    if (got_ptr1.size() != 16) begin failures++; $display("FAIL loop_cnt1 got=%0d exp=16", got_ptr1.size()); end
    for (int i = 0; i < 16 && i < got_ptr0.size(); i++) begin
      checks++;
      if (got_ptr0[i] !== 4'd3 || got_last0[i] !== (i == 15)) begin
        failures++;
        $display("FAIL loop_node idx=%0d ptr=%0d last=%b exp ptr=3 last=%b",
                 i, got_ptr0[i], got_last0[i], (i == 15));
      end
    end
    push(4'd6);
    repeat (4) cycle();
    checks++;
    if (err_loop0 !== 1'b1) begin failures++; $display("FAIL loop_sticky got=%b exp=1", err_loop0); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    wr(1, 5); wr(5, 3);
    out_ptr_rdy = 1'b1;
    push(4'd1);
    push(4'd2);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_ptr_vld0 && out_ptr0 == 4'd5) seen = 1'b1;
      else cycle();
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL mid_node2 got=not_seen exp=ptr5"); end
    rst = 1'b0;
    #1;
    checks += 2;
    if (out_ptr_vld0 !== 1'b0 || busy0 !== 1'b0 || out_ptr0 !== 4'd0) begin
      failures++;
      $display("FAIL mid_rst0 vld=%b busy=%b ptr=%0d exp 0 0 0", out_ptr_vld0, busy0, out_ptr0);
    end
    if (out_ptr_vld1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++; $display("FAIL mid_rst1 vld=%b busy=%b exp 0 0", out_ptr_vld1, busy1);
    end
    cycle();
    rst = 1'b1;
    clear_mon();
    mon_en = 1'b1;
    repeat (5) cycle();
    checks++;
    if (got_ptr0.size() != 0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL mid_quiet outputs=%0d busy=%b exp 0 0", got_ptr0.size(), busy0);
    end
    push(4'd1);
    repeat (6) cycle();
    mon_en = 1'b0;
    checks++;
    if (got_ptr0.size() != 1) begin
      failures++; $display("FAIL mid_restart_cnt got=%0d exp=1", got_ptr0.size());
    end else if (got_ptr0[0] !== 4'd1 || got_last0[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_restart ptr=%0d last=%b exp ptr=1 last=1", got_ptr0[0], got_last0[0]);
    end
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_next = '0;
    start = '0; start_vld = 1'b0; out_ptr_rdy = 1'b0;
    test_reset();
    test_latency();
    test_lists();
    test_backpressure();
    test_fifo_full();
    test_loop_guard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ll_walker.md
LL_WALKER -- requirements
Module: ll_walker

Interface
REQ-001 Parameter N, default 256, number of list nodes; node index 0 is the null pointer.
REQ-002 Parameter W_PTR, default $clog2(N), pointer width.
REQ-003 Parameter FIFO_DEPTH, default 4, start-request FIFO entries (power of two, >=2).
REQ-004 Parameter NO_GAP, default 0; 1 = back-to-back lists with no idle cycle, 0 = one idle cycle between lists.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  single clock; all state is updated on its rising edge.
REQ-007 rst  in  1  asynchronous reset, active-low.
REQ-008 cfg_we  in  1  next-table write enable.
REQ-009 cfg_addr  in  W_PTR  next-table entry to write.
REQ-010 cfg_next  in  W_PTR  successor value written to entry cfg_addr.
REQ-011 start  in  W_PTR  list head pointer.
REQ-012 start_vld  in  1  start request valid.
REQ-013 start_rdy  out  1  start FIFO not full.
REQ-014 out_ptr  out  W_PTR  current node pointer.
REQ-015 out_ptr_vld  out  1  out_ptr valid.
REQ-016 out_ptr_rdy  in  1  consumer accepts out_ptr.
REQ-017 out_last  out  1  out_ptr is the final node of its list.
REQ-018 busy  out  1  walk in progress or FIFO non-empty.
REQ-019 err_loop  out  1  sticky flag: a walk exceeded N nodes.

Function
REQ-020 Next table: N x W_PTR registers; a write with cfg_we=1 is visible to lookups from the following cycle; a same-cycle lookup of that entry returns the old value.
REQ-021 Start handshake: a request is accepted on start_vld & start_rdy; start_rdy = !fifo_full, with no dependence on start_vld.
REQ-022 An accepted start == 0 SHALL be popped and discarded without producing output.
REQ-023 FSM states: IDLE, WALK.
  - IDLE -> WALK when the FIFO head is non-zero; the output is loaded with the head and popped.
  - WALK -> IDLE on acceptance of the out_last node when no successor list is loaded.
REQ-024 Output latency: the first node appears on out_ptr one cycle after the head reaches the FIFO front in IDLE; a FIFO push in cycle t makes the FIFO front visible in cycle t+1.
REQ-025 Output hold: while out_ptr_vld & !out_ptr_rdy, out_ptr, out_ptr_vld and out_last SHALL hold stable.
REQ-026 Advance: on an output handshake with out_last=0, out_ptr <= next[out_ptr] in the next cycle, with no bubble.
REQ-027 out_last SHALL be 1 when next[out_ptr]==0 or when the loop guard fires.
REQ-028 NO_GAP=1: on the out_last handshake with the FIFO non-empty and a non-zero head, the next cycle SHALL present the new head.
REQ-029 NO_GAP=0: after the out_last handshake, out_ptr_vld SHALL be 0 for exactly one cycle before the next list begins.
REQ-030 Loop guard: a W_PTR+1-bit node counter counts nodes per list; when it reaches N with next!=0, out_last=1 is forced, the walk ends and err_loop sets; err_loop is cleared only by reset.
REQ-031 Simultaneous FIFO push and pop SHALL be allowed when full; the pop frees the slot and start_rdy deasserts only when the FIFO is full after the cycle's pop.
REQ-032 busy = (state==WALK) | !fifo_empty.

Reset
REQ-033 While rst=0: the FIFO is empty, state is IDLE, out_ptr=0, out_ptr_vld=0, out_last=0, err_loop=0, all next entries are 0, and start_rdy=1 after reset deassertion.
REQ-034 Reset asserted mid-walk SHALL drop the current list and all queued starts immediately; no output follows until a new start arrives.

Structure
REQ-035 Package ll_pkg SHALL hold NULL_PTR, the state enum and the function computing W_PTR from N.
REQ-036 The start FIFO SHALL be a sub-module ll_start_fifo (parametrised on depth and width).
REQ-037 The next table, FSM, output register and loop guard SHALL reside in ll_walker.

Verification
REQ-038 Table 1->5->3->10->0, 2->4->0, 7->15->8->0, 6->0; starts 7,6,2,1 with out_ptr_rdy=1 -> outputs 7,15,8 | 6 | 2,4 | 1,5,3,10, with out_last on 8, 6, 4 and 10.
REQ-039 Same stimulus with NO_GAP=1 -> exactly one out_ptr_vld=0 cycle at start only; with NO_GAP=0 -> a single idle cycle after each out_last.
REQ-040 Backpressure: out_ptr_rdy toggling randomly on list 9->14->11->13->12 -> order 9,14,11,13,12, with values stable while stalled.
REQ-041 Push 6 starts with FIFO_DEPTH=4 and the consumer stalled -> start_rdy falls after 4 accepts; no start is lost.
REQ-042 Table entry next[3]=3, start 3, N=16 -> 16 outputs of 3, out_last on the 16th, err_loop=1 sticky.
REQ-043 Reset pulsed during the 2nd node of list 1 -> out_ptr_vld=0 and busy=0 in the same cycle; table cleared; start 1 after reset -> single node 1 with out_last=1.
